// File: rtl/music_pkg.sv
// Shared widths, types and FSM state encodings for the song sequencer.
package music_pkg;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int ADDR_W  = 5;
    localparam int END_DUR = 0;

    typedef logic [1:0] song_t;
    typedef logic [2:0] state_t;

    localparam state_t RDY    = 3'd0;
    localparam state_t LOOKUP = 3'd1;
    localparam state_t EMIT   = 3'd2;
    localparam state_t WAIT   = 3'd3;
    localparam state_t HALT   = 3'd4;
endpackage

// File: rtl/song_rom.sv
// Synchronous-read note ROM, one word of {note, duration} per {song, index}.
// The image named "song_rom.hex" is held as a decode table so the ROM needs no load step.
module song_rom #(
    parameter int    NOTE_W   = 6,
    parameter int    DUR_W    = 6,
    parameter int    ADDR_W   = 5,
    parameter string ROM_FILE = "song_rom.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_en,
    input  logic [ADDR_W+1:0]         addr,
    output logic [NOTE_W+DUR_W-1:0]   data
);
    // Unknown image names read back as all end markers, so playback halts at once.
    localparam bit BUILTIN = (ROM_FILE == "song_rom.hex");

    function automatic logic [NOTE_W+DUR_W-1:0] image(input logic [ADDR_W+1:0] a);
        logic [1:0]        s;
        logic [ADDR_W-1:0] i;
        logic [NOTE_W-1:0] n;
        logic [DUR_W-1:0]  d;
        s = a[ADDR_W+1:ADDR_W];
        i = a[ADDR_W-1:0];
        n = '0;
        d = '0;
        case (s)
            2'd0: begin
                if (i < ADDR_W'(3)) begin
                    n = NOTE_W'(32'h10 + 32'(i));
                    d = DUR_W'(32'd4 + 32'(i));
                end
            end
            2'd1: begin
                n = NOTE_W'(32'h20 + 32'(i));
                d = DUR_W'(2);
            end
            default: ;
        endcase
        return {n, d};
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            data <= '0;
        else if (rd_en)
            data <= BUILTIN ? image(addr) : '0;
    end
endmodule

// File: rtl/song_reader.sv
// Note sequencer: walks the selected song in the ROM and hands notes to the
// note player over a new_note / note_done handshake.
//   state  | meaning
//   RDY    | idle between notes, waits for play
//   LOOKUP | ROM read of {song, idx}
//   EMIT   | ROM word valid; pulse new_note, or song_done on an end marker
//   WAIT   | note playing, waits for note_done
//   HALT   | song finished, waits for reset_play
module song_reader #(
    parameter int    NOTE_W   = music_pkg::NOTE_W,
    parameter int    DUR_W    = music_pkg::DUR_W,
    parameter int    ADDR_W   = music_pkg::ADDR_W,
    parameter string ROM_FILE = "song_rom.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [1:0]        song,
    input  logic              reset_play,
    input  logic              note_done,
    output logic              new_note,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              song_done
);
    import music_pkg::*;

    state_t                   state;
    logic [ADDR_W-1:0]        idx;
    logic                     done_q;
    logic                     rd_en;
    logic                     end_mark;
    logic [NOTE_W+DUR_W-1:0]  rom_q;
    song_t                    song_sel;

    assign song_sel = song;
    assign note     = rom_q[NOTE_W+DUR_W-1:DUR_W];
    assign duration = rom_q[DUR_W-1:0];
    assign end_mark = (duration == DUR_W'(END_DUR));

    // A restart suppresses everything else in its cycle, including the ROM load.
    assign rd_en     = (state == LOOKUP) && !reset_play;
    assign new_note  = (state == EMIT) && !end_mark && !reset_play;
    assign song_done = !reset_play && (done_q || ((state == EMIT) && end_mark));

    song_rom #(
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .ADDR_W   (ADDR_W),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .rd_en (rd_en),
        .addr  ({song_sel, idx}),
        .data  (rom_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RDY;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (reset_play) begin
                state <= RDY;
                idx   <= '0;
            end else begin
                case (state)
                    RDY:    if (play) state <= LOOKUP;
                    LOOKUP: state <= EMIT;
                    EMIT: begin
                        if (end_mark) begin
                            idx   <= '0;
                            state <= HALT;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (note_done) begin
                            if (idx == '1) begin
                                idx    <= '0;
                                done_q <= 1'b1;
                                state  <= HALT;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= RDY;
                            end
                        end
                    end
                    HALT:    ;
                    default: state <= RDY;
                endcase
            end
        end
    end
endmodule

// File: doc/song_reader.md
# song_reader

Note sequencer on the far side of the `mcu` control interface. It consumes `play`, `song` and `reset_play`, and steps through the selected song's note ROM, presenting one note at a time to the note player over a `new_note`/`note_done` handshake. When the song ends it pulses `song_done` back to `mcu`.

## Interface
Parameters:
- `NOTE_W`, 6: note code width.
- `DUR_W`, 6: duration width; a duration of 0 is the end-of-song marker.
- `ADDR_W`, 5: note index width, giving 32 notes per song.
- `ROM_FILE`, "song_rom.hex": `$readmemh` image with 128 words of {note, duration}; the word address is {song, index}.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; returns the whole block to its reset state.
- `play`  in  1  from `mcu`; 1 = fetch and issue notes, 0 = pause.
- `song`  in  2  from `mcu`; selects the song.
- `reset_play`  in  1  from `mcu`; synchronous restart of the current song at index 0.
- `note_done`  in  1  from the note player; 1-cycle pulse when the issued note has finished.
- `new_note`  out  1  1-cycle pulse; `note` and `duration` are valid.
- `note`  out  NOTE_W  current note code.
- `duration`  out  DUR_W  current note length.
- `song_done`  out  1  1-cycle pulse at the end of the song.

## Operation
The FSM has five states: RDY, LOOKUP, EMIT, WAIT and HALT.

- **RDY:** if `play`=1, go to LOOKUP. Otherwise hold.
- **LOOKUP:** ROM read enable is asserted with address {`song`, `idx`}. Go to EMIT.
- **EMIT:**
  - If the ROM `duration`≠0: `new_note`=1, go to WAIT.
  - If the ROM `duration`=0 (end marker): `song_done`=1, `idx`←0, go to HALT, and do not pulse `new_note`.
- **WAIT:** hold until `note_done`=1, then:
  - If `idx`=31: `song_done`=1, `idx`←0, go to HALT.
  - Otherwise: `idx`←`idx`+1, go to RDY.
  - `play`=0 in WAIT does not abort the note; pausing the note itself is the note player's job.
- **HALT:** hold until `reset_play`=1. This prevents a replay before `mcu` reacts to `song_done`.

Data path and event rules:
- `note` and `duration` come straight from the ROM output register. That register loads only in LOOKUP, so both values hold stable from EMIT through WAIT.
- `reset_play`=1 in any state: next state is RDY and `idx`←0. No `song_done` or `new_note` pulse is produced in that cycle. `note` and `duration` keep their values.
- Priority when events coincide: `reset` > `reset_play` > `note_done`.
- `note_done` is ignored in every state except WAIT.
- `song` is sampled only in LOOKUP. `mcu` changes songs via `reset_play`, so a mid-song `song` change without `reset_play` takes effect at the next note.
- `idx` arithmetic is unsigned ADDR_W bits. Wrap from 31 to 0 happens only through the end-of-song path, never by silent overflow.

## Timing
- Reset values: state RDY, `idx` 0, `note` 0, `duration` 0, `new_note` 0, `song_done` 0.
- If `play`=1 is sampled in RDY at edge E0: LOOKUP after E0, EMIT after E1, and `new_note` is high in the cycle after E1. Latency is 2 cycles.
- If `note_done` is sampled in WAIT at edge En with `play` still 1: the next `new_note` is high in the cycle after En+2. The note-to-note gap is 3 cycles.
- `song_done` rises in the cycle after the edge that sampled `note_done` for index 31, or in the EMIT cycle for an end marker. It is high for exactly 1 cycle.
- If `reset_play` is sampled at edge E: RDY after E. With `play`=1, `new_note` follows 2 cycles after that.
- `play`=0 in RDY: no ROM access and no output change.

## Structure
- Shared package `music_pkg`:
  - `NOTE_W`, `DUR_W`, `ADDR_W` defaults.
  - The `song_t` 2-bit type.
  - The state enum {RDY, LOOKUP, EMIT, WAIT, HALT}.
  - `END_DUR` = 0.
- Sub-module `song_rom`: synchronous-read ROM, 2^(2+ADDR_W) × (NOTE_W+DUR_W), with `rd_en` and a 1-cycle read. `song_reader` itself holds the FSM and the `idx` counter.

## Test plan
The test ROM image contains:
- Song 0: 3 notes {0x10,4}, {0x11,5}, {0x12,6}, then an end marker.
- Song 1: all 32 entries {0x20+i, 2}.

Directed scenarios:
1. Reset, `play`=1, `song`=0, with `note_done` pulsed 5 cycles after each `new_note` → `new_note` ×3 carrying (0x10,4), (0x11,5), (0x12,6), then one `song_done` pulse in the EMIT cycle of index 3, then HALT with no further pulses.
2. `song`=1, full playback → 32 `new_note` pulses with notes 0x20..0x3F, `song_done` 1 cycle after the edge that samples the final `note_done`, and `idx` back to 0.
3. Drop `play` to 0 while in WAIT during song 0 note 1, pulse `note_done`, hold `play` low for 10 cycles → no `new_note` for those 10 cycles; `new_note` (0x12,6) appears 2 cycles after `play` returns to 1.
4. `reset_play` coincident with `note_done` in WAIT at index 2 → no `song_done`, `idx`=0, and the next `new_note` carries 0x10.
5. HALT followed by `reset_play` and `play`=1 → playback restarts with (0x10,4) and 2-cycle latency.
6. `reset` asserted mid-note → every output is 0 on the next cycle; `note_done` is then ignored while in RDY.
